w_buf_loader: RTL and testbench

- Write-side counterpart of the weight buffer.
- Accepts a serial stream of WIDTH-bit weight words over a valid/ready handshake and packs each group of COL words into one row.
- Writes DEPTH rows into an internal row memory and serves registered full-row reads to the PE array.
- Lane ordering on the read port matches the existing weight-buffer convention: the first streamed word of a row appears in the most-significant lane.

---
 rtl/w_buf_pkg.sv | 20 ++
 rtl/w_row_ram.sv | 40 ++++
 rtl/w_buf_loader.sv | 103 ++++++++++
 tb/tb_w_buf_loader.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/w_buf_pkg.sv
// Shared definitions for the weight-buffer family: loader FSM states,
// default geometry, and the stream-word to lane mapping.
package w_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_COL   = 10;

  // Bit offset of stream word k within a row; the first word lands in the top lane.
  function automatic int lane_offset(input int k, input int col, input int width);
    return (col - 1 - k) * width;
  endfunction

endpackage

// File: rtl/w_row_ram.sv
// Simple dual-port row RAM: one write port, one registered read-first read port
// that returns zero when the read is disabled or the address is out of range.
module w_row_ram #(
  parameter int ROW_WIDTH  = 320,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [ROW_WIDTH-1:0]  wdata,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ROW_WIDTH-1:0]  rd_dout
);

  logic [ROW_WIDTH-1:0] mem [DEPTH];
  logic                 addr_ok;

  assign addr_ok = (int'(rd_addr) < DEPTH);

  // Storage has no reset so it maps onto block RAM and survives an aborted load.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      rd_dout <= '0;
    end else if (rd_en && addr_ok) begin
      rd_dout <= mem[rd_addr];
    end else begin
      rd_dout <= '0;
    end
  end

endmodule

// File: rtl/w_buf_loader.sv
// Streams WIDTH-bit weight words in, packs COL of them per row (first word in
// the top lane) and writes DEPTH rows into the row RAM served to the PE array.
module w_buf_loader
  import w_buf_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int COL        = DEF_COL,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(COL)
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start,
  input  logic                  s_valid,
  input  logic [WIDTH-1:0]      s_data,
  output logic                  s_ready,
  output logic                  busy,
  output logic                  done,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH*COL-1:0]  rd_dout
);

  localparam int ROW_WIDTH = WIDTH * COL;

  state_t                state, state_next;
  logic [CNT_WIDTH-1:0]  col_cnt;
  logic [ADDR_WIDTH-1:0] row_cnt;
  logic [ROW_WIDTH-1:0]  pack, pack_next;
  logic                  accept, last_col, last_row, row_we;

  // Acceptance is decoded from the state directly so it does not loop through s_ready.
  assign accept    = s_valid && (state == LOAD);
  assign last_col  = (col_cnt == CNT_WIDTH'(COL - 1));
  assign last_row  = (row_cnt == ADDR_WIDTH'(DEPTH - 1));
  assign pack_next = {pack[(COL-1)*WIDTH-1:0], s_data};
  assign row_we    = accept && last_col;

  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        busy    = 1'b1;
        s_ready = 1'b1;
        if (row_we && last_row) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      pack    <= '0;
    end else begin
      state <= state_next;
      // start only counts outside LOAD; a pulse mid-load leaves the counters alone.
      if (start && (state != LOAD)) begin
        col_cnt <= '0;
        row_cnt <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + ADDR_WIDTH'(1);
        end else begin
          col_cnt <= col_cnt + CNT_WIDTH'(1);
        end
      end
      if (accept) begin
        pack <= pack_next;
      end
    end
  end

  w_row_ram #(
    .ROW_WIDTH  (ROW_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_row_ram (
    .clk     (clk),
    .rst_i   (rst_i),
    .we      (row_we),
    .waddr   (row_cnt),
    .wdata   (pack_next),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dout (rd_dout)
  );

endmodule

// File: tb/tb_w_buf_loader.sv
// Scoreboard bench for w_buf_loader: stimulus predicts post-edge outputs from a
// word-index reference model; a monitor compares them after every clock edge.
module tb_w_buf_loader;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int COL   = 3;
  localparam int AW    = $clog2(DEPTH);
  localparam int RW    = WIDTH * COL;

  logic             clk = 1'b0;
  logic             rst_i = 1'b0;
  logic             start = 1'b0;
  logic             s_valid = 1'b0;
  logic [WIDTH-1:0] s_data = '0;
  logic             s_ready, busy, done;
  logic             rd_en = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [RW-1:0]    rd_dout;

  typedef struct {
    logic [RW-1:0] rd;
    logic          ready;
    logic          busy;
    logic          done;
    int            id;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_steps  = 0;

  // Reference model: rows, word count of the current load, status flags.
  logic [RW-1:0] ref_mem [DEPTH];
  logic [RW-1:0] stage = '0;
  bit            m_loading = 1'b0;
  bit            m_done    = 1'b0;
  int            m_words   = 0;

  always #5 clk = ~clk;

  w_buf_loader #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .COL   (COL)
  ) dut (
    .clk     (clk),
    .rst_i   (rst_i),
    .start   (start),
    .s_valid (s_valid),
    .s_data  (s_data),
    .s_ready (s_ready),
    .busy    (busy),
    .done    (done),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_dout (rd_dout)
  );

  task automatic chk(input string name, input int id, input logic [RW-1:0] got, input logic [RW-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, got, want);
    end
  endtask

  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      #1;
      chk("rd_dout", e.id, rd_dout, e.rd);
      chk("s_ready", e.id, RW'(s_ready), RW'(e.ready));
      chk("busy",    e.id, RW'(busy),    RW'(e.busy));
      chk("done",    e.id, RW'(done),    RW'(e.done));
      $display("step %0d: rd_dout=%h s_ready=%b busy=%b done=%b", e.id, rd_dout, s_ready, busy, done);
    end
  end

  // One clock cycle: drive inputs, predict the state after the edge, queue it.
  task automatic step(input bit v, input logic [WIDTH-1:0] d, input bit st,
                      input bit re, input logic [AW-1:0] ra);
    exp_t e;
    s_valid = v; s_data = d; start = st; rd_en = re; rd_addr = ra;
    n_steps++;
    e.id = n_steps;
    if (!rst_i) begin
      e.rd = '0; e.ready = 1'b0; e.busy = 1'b0; e.done = 1'b0;
    end else begin
      e.rd = (re && int'(ra) < DEPTH) ? ref_mem[ra] : '0;
      if (m_loading) begin
        if (v) begin
          int k;
          k = m_words % COL;
          stage[(COL-1-k)*WIDTH +: WIDTH] = d;
          if (k == COL - 1) ref_mem[m_words / COL] = stage;
          m_words++;
          if (m_words == DEPTH * COL) begin
            m_loading = 1'b0;
            m_done    = 1'b1;
          end
        end
      end else if (st) begin
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_words   = 0;
      end
      e.ready = m_loading; e.busy = m_loading; e.done = m_done;
    end
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b0, '0, 1'b0, 1'b1, AW'(a));
  endtask

  // mode 0: back-to-back, 1: valid pattern 1,0,0, 2: random gaps and reads.
  task automatic load(input logic [WIDTH-1:0] words[$], input int mode);
    int i = 0;
    int c = 0;
    step(1'b0, '0, 1'b1, 1'b0, '0);
    while (i < words.size() && c < 500) begin
      bit v;
      bit re;
      case (mode)
        0:       v = 1'b1;
        1:       v = (c % 3 == 0);
        default: v = ($urandom_range(99) >= 40);
      endcase
      re = (mode == 2) && ($urandom_range(1) == 1);
      step(v, v ? words[i] : 8'hFF, 1'b0, re, AW'($urandom_range(DEPTH - 1)));
      if (v) i++;
      c++;
    end
    if (i < words.size()) begin
      n_fail++;
      $display("FAIL load_budget: accepted %0d words, expected %0d", i, words.size());
    end
  endtask

  function automatic void rand_words(output logic [WIDTH-1:0] q[$]);
    q = {};
    for (int i = 0; i < DEPTH * COL; i++) q.push_back(WIDTH'($urandom));
  endfunction

  initial begin
    logic [WIDTH-1:0] w[$];

    // Reset held: inputs toggling must not move anything.
    @(negedge clk);
    step(1'b1, 8'h55, 1'b1, 1'b1, '0);
    step(1'b1, 8'h66, 1'b1, 1'b0, '0);
    rst_i = 1'b1;
    idle();
    idle();

    // Basic load and read-back.
    w = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load(w, 0);
    idle();
    rd(0); rd(1); idle();

    // Gapped stream, same data; FF on invalid cycles must never land.
    load(w, 1);
    idle();
    rd(0); rd(1); idle();

    // Collision: read row 0 on the cycle it is rewritten.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, '0);
    step(1'b1, 8'hBB, 1'b0, 1'b0, '0);
    step(1'b1, 8'hCC, 1'b0, 1'b1, '0);
    step(1'b0, '0, 1'b0, 1'b1, '0);
    step(1'b1, 8'h04, 1'b0, 1'b0, '0);
    step(1'b1, 8'h05, 1'b0, 1'b0, '0);
    step(1'b1, 8'h06, 1'b0, 1'b1, 1'b1);
    rd(0); rd(1);

    // Reset mid-load after a fresh complete load.
    load(w, 0);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 8'h11, 1'b0, 1'b0, '0);
    step(1'b1, 8'h12, 1'b0, 1'b0, '0);
    step(1'b1, 8'h13, 1'b0, 1'b0, '0);
    step(1'b1, 8'h14, 1'b0, 1'b0, '0);
    rst_i = 1'b0;
    m_loading = 1'b0; m_done = 1'b0; m_words = 0;
    step(1'b1, 8'h15, 1'b1, 1'b1, '0);
    rst_i = 1'b1;
    idle();
    rd(0); rd(1);
    step(1'b1, 8'h16, 1'b0, 1'b0, '0);
    rand_words(w);
    load(w, 0);
    rd(0); rd(1);

    // start mid-load is ignored; the seventh word is refused.
    step(1'b0, '0, 1'b1, 1'b0, '0);
    step(1'b1, 8'h21, 1'b0, 1'b0, '0);
    step(1'b1, 8'h22, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'h23 + i), 1'b0, 1'b0, '0);
    step(1'b1, 8'h27, 1'b0, 1'b0, '0);
    rd(0); rd(1); idle();

    // Randomized loads with gaps and interleaved reads.
    for (int n = 0; n < 4; n++) begin
      rand_words(w);
      load(w, 2);
      for (int r = 0; r < 4; r++) begin
        step(1'b0, '0, 1'b0, 1'($urandom_range(1)), AW'($urandom_range(DEPTH - 1)));
      end
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
